// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed driver for a bank of common-anode
// seven-segment digits. Scans one digit per REFRESH_DIV clocks, decodes hex
// nibbles to active-low a..g segments, suppresses leading zeros, drives
// decimal points, and only swaps in a newly loaded value at the frame
// boundary so a frame never shows a mix of old and new digits.
module sevenseg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic                  BLANK_IN,
    output logic [0:6]            SEV,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN,
    output logic                  PENDING,
    output logic                  FRAME
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan timing
    logic [DIV_W-1:0]     r_div;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_frame;

    // Load handshake and display register
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [4*DIGITS-1:0]  r_buf_val;
    logic [DIGITS-1:0]    r_buf_dp;
    logic                 r_pending;

    // Registered pin drivers
    logic [DIGITS-1:0]    r_an;
    logic [0:6]           r_sev;
    logic                 r_dp;

    logic                 w_tc;
    logic                 w_boundary;
    logic [DIGITS-1:0]    w_lz_mask;
    logic                 w_zero_run;
    logic [3:0]           w_nib;
    logic                 w_dp_sel;
    logic                 w_suppress;

    // Hex nibble to active-low a..g (leftmost bit is segment a)
    function automatic logic [0:6] f_decode(input logic [3:0] nib);
        logic [0:6] seg;
        unique case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0001100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign w_tc       = (r_div == DIV_LAST);
    assign w_boundary = w_tc && (r_idx == IDX_LAST);

    // Mark digits whose nibble and every higher nibble are zero; digit 0 is never marked
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        if (LZ_SUPPRESS != 0) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                w_zero_run   = w_zero_run && (r_disp_val[4*i +: 4] == 4'h0);
                w_lz_mask[i] = w_zero_run;
            end
        end
    end

    // Select the nibble, decimal point and suppression flag of the active digit
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_suppress = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib      = r_disp_val[4*i +: 4];
                w_dp_sel   = r_disp_dp[i];
                w_suppress = w_lz_mask[i];
            end
        end
    end

    // Refresh divider, digit index and frame pulse
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values
        if (RST) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_tc) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Capture loads into the pending buffer; only touch the display register at the boundary
    always_ff @(posedge CLK) begin
        // NOTE: the display register is reset too, because the outputs decode it from the first cycle after reset
        if (RST) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_buf_val  <= '0;
            r_buf_dp   <= '0;
            r_pending  <= 1'b0;
        end else if (LOAD && w_boundary) begin
            r_disp_val <= VALUE;
            r_disp_dp  <= DP_IN;
            r_pending  <= 1'b0;
        end else if (LOAD) begin
            r_buf_val  <= VALUE;
            r_buf_dp   <= DP_IN;
            r_pending  <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_disp_val <= r_buf_val;
            r_disp_dp  <= r_buf_dp;
            r_pending  <= 1'b0;
        end
    end

    // Register anode, segment and decimal-point drivers from the current index and display
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_an  <= '1;
            r_sev <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= BLANK_IN ? '1 : ~(DIGITS'(1) << r_idx);
            r_sev <= w_suppress ? 7'b1111111 : f_decode(w_nib);
            r_dp  <= ~w_dp_sel;
        end
    end

    assign AN      = r_an;
    assign SEV     = r_sev;
    assign DP      = r_dp;
    assign PENDING = r_pending;
    assign FRAME   = r_frame;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver: two instances (leading-zero suppression on
// and off) share stimulus. Frames are driven one slot at a time; for every
// slot the expected pin state is queued as the stimulus is applied and popped
// and compared once the DUT has clocked it out.
module tb_sevenseg_scan_driver;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic                LOAD;
    logic [4*DIGITS-1:0] VALUE;
    logic [DIGITS-1:0]   DP_IN;
    logic                BLANK_IN;

    logic [0:6]          sev_a, sev_b;
    logic                dp_a, dp_b;
    logic [DIGITS-1:0]   an_a, an_b;
    logic                pend_a, pend_b;
    logic                frame_a, frame_b;

    typedef struct {
        logic [3:0] an;
        logic [6:0] sev_a;
        logic [6:0] sev_b;
        logic       dp;
        logic       pend;
        logic       frame;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] seg_tab[16];
    int         n_assert = 0;
    int         n_fail   = 0;
    int         frame_no = 0;

    always #5 CLK = ~CLK;

    sevenseg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .LZ_SUPPRESS(1)) dut_a (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
        .SEV(sev_a), .DP(dp_a), .AN(an_a), .PENDING(pend_a), .FRAME(frame_a)
    );

    sevenseg_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .LZ_SUPPRESS(0)) dut_b (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .VALUE(VALUE), .DP_IN(DP_IN), .BLANK_IN(BLANK_IN),
        .SEV(sev_b), .DP(dp_b), .AN(an_b), .PENDING(pend_b), .FRAME(frame_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, got, want);
            $error("check %s failed", tag);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Expected segments for digit i of val; suppressed when nothing nonzero sits at or above it
    function automatic logic [6:0] exp_seg(input logic [15:0] val, input int i, input bit lz);
        logic [15:0] upper;
        upper = val >> (4 * i);
        if (lz && i > 0 && upper == 16'h0) return 7'b1111111;
        return seg_tab[upper[3:0]];
    endfunction

    // Wait (bounded) until FRAME is seen; afterwards the next edge starts digit 0 of a new frame
    task automatic wait_frame();
        int n;
        n = 0;
        while (frame_a !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("wait_frame", 16'(frame_a), 16'h1);
    endtask

    // Run one aligned frame: disp/dpv is what the display register holds this frame,
    // blank_from is the first slot with BLANK_IN=1, l1/l2 are optional load slots (-1 = none)
    task automatic run_frame(input logic [15:0] disp, input logic [3:0] dpv, input int blank_from,
                             input int l1_at, input logic [15:0] l1_val, input logic [3:0] l1_dp,
                             input int l2_at, input logic [15:0] l2_val);
        exp_t e;
        int   idx;
        for (int j = 0; j < 16; j++) begin
            idx     = j / 4;
            e.an    = (j >= blank_from) ? 4'hF : ~(4'b0001 << idx);
            e.sev_a = exp_seg(disp, idx, 1'b1);
            e.sev_b = exp_seg(disp, idx, 1'b0);
            e.dp    = ~dpv[idx];
            e.pend  = (l1_at >= 0) && (j >= l1_at) && (j < 15);
            e.frame = (j == 15);
            exp_q.push_back(e);

            BLANK_IN = (j >= blank_from);
            LOAD     = (j == l1_at) || (j == l2_at);
            VALUE    = (j == l2_at) ? l2_val : l1_val;
            DP_IN    = l1_dp;
            tick();

            e = exp_q.pop_front();
            check($sformatf("f%0d s%0d AN", frame_no, j),      16'(an_a),    16'(e.an));
            check($sformatf("f%0d s%0d SEV", frame_no, j),     16'(sev_a),   16'(e.sev_a));
            check($sformatf("f%0d s%0d SEV_nolz", frame_no, j), 16'(sev_b),  16'(e.sev_b));
            check($sformatf("f%0d s%0d DP", frame_no, j),      16'(dp_a),    16'(e.dp));
            check($sformatf("f%0d s%0d PENDING", frame_no, j), 16'(pend_a),  16'(e.pend));
            check($sformatf("f%0d s%0d FRAME", frame_no, j),   16'(frame_a), 16'(e.frame));
        end
        LOAD     = 1'b0;
        BLANK_IN = 1'b0;
        frame_no++;
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        RST      = 1'b1;
        LOAD     = 1'b0;
        VALUE    = '0;
        DP_IN    = '0;
        BLANK_IN = 1'b0;

        // Reset held for three edges
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst AN",      16'(an_a),    16'hF);
        check("rst AN_nolz", 16'(an_b),    16'hF);
        check("rst SEV",     16'(sev_a),   16'h7F);
        check("rst DP",      16'(dp_a),    16'h1);
        check("rst PENDING", 16'(pend_a),  16'h0);
        check("rst FRAME",   16'(frame_a), 16'h0);

        // First edge after release shows digit 0 of an all-zero display
        RST = 1'b0;
        tick();
        check("rel AN",       16'(an_a),  16'hE);
        check("rel SEV",      16'(sev_a), 16'h01);
        check("rel SEV_nolz", 16'(sev_b), 16'h01);
        check("rel DP",       16'(dp_a),  16'h1);

        wait_frame();
        // Zero display; 1234 loaded on the boundary cycle itself
        run_frame(16'h0000, 4'h0, 16, 15, 16'h1234, 4'h0, -1, 16'h0);
        // 1234 scanned; ABCD loaded mid-frame must wait
        run_frame(16'h1234, 4'h0, 16, 3, 16'hABCD, 4'h0, -1, 16'h0);
        // ABCD scanned; two loads, the later 0F00 must win
        run_frame(16'hABCD, 4'h0, 16, 2, 16'h5555, 4'h0, 9, 16'h0F00);
        // 0F00 scanned; 00E0 loaded on the boundary, PENDING never rises
        run_frame(16'h0F00, 4'h0, 16, 15, 16'h00E0, 4'h0, -1, 16'h0);
        run_frame(16'h00E0, 4'h0, 16, 15, 16'h0005, 4'h0, -1, 16'h0);
        // Leading zeros: 0005, then all-zero
        run_frame(16'h0005, 4'h0, 16, 15, 16'h0000, 4'h0, -1, 16'h0);
        run_frame(16'h0000, 4'h0, 16, 15, 16'h1234, 4'b0010, -1, 16'h0);
        // Decimal point on digit 1, blanking from slot 10 while a load is pending
        run_frame(16'h1234, 4'b0010, 10, 5, 16'hABCD, 4'h0, -1, 16'h0);
        // Scan continued through blanking: normal frame with FRAME on time
        run_frame(16'hABCD, 4'h0, 16, -1, 16'h0, 4'h0, -1, 16'h0);

        // Reset while a load is pending discards it
        LOAD  = 1'b1;
        VALUE = 16'h9999;
        DP_IN = 4'hF;
        tick();
        LOAD = 1'b0;
        check("pre-rst PENDING", 16'(pend_a), 16'h1);
        RST = 1'b1;
        tick();
        check("mid-rst PENDING", 16'(pend_a),  16'h0);
        check("mid-rst AN",      16'(an_a),    16'hF);
        check("mid-rst SEV",     16'(sev_a),   16'h7F);
        check("mid-rst DP",      16'(dp_a),    16'h1);
        check("mid-rst FRAME",   16'(frame_a), 16'h0);
        RST = 1'b0;
        tick();
        check("post-rst AN",  16'(an_a),  16'hE);
        check("post-rst SEV", 16'(sev_a), 16'h01);
        check("post-rst DP",  16'(dp_a),  16'h1);
        wait_frame();
        run_frame(16'h0000, 4'h0, 16, -1, 16'h0, 4'h0, -1, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
